// File: rtl/spec_bram_writer.sv
// Frame-aligned FFT spectrum capture into BRAM port A: waits for a frame boundary,
// writes one FRAME_LEN-bin frame, then holds until disarmed.
module spec_bram_writer #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned FRAME_LEN = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic [31:0]       status,
    output logic              busy,
    output logic              done,
    output logic              frame_err
);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(FRAME_LEN - 1);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = SYNC;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            SYNC: begin
                if (!arm) begin
                    state_d = IDLE;
                end else if (s_tvalid && s_tlast) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (s_tvalid) begin
                    // Aligned only when tlast coincides exactly with the last bin index.
                    if (s_tlast == (cnt_q == LAST_IDX)) begin
                        we_d   = 1'b1;
                        addr_d = cnt_q[ADDR_W-1:0];
                        din_d  = s_tdata;
                        cnt_d  = cnt_q + (ADDR_W+1)'(1);
                        if (s_tlast) begin
                            state_d = DONE;
                        end
                    end else begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = s_tlast ? CAPTURE : SYNC;
                    end
                end
                // Abort overrides the next state but the accepted beat above still writes.
                if (!arm) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (!arm) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE && state_q != IDLE) begin
            err_d = 1'b0;
        end
    end

    assign s_tready  = 1'b1;
    assign bram_en   = we_q;
    assign bram_we   = we_q;
    assign bram_addr = addr_q;
    assign bram_din  = din_q;
    assign status    = 32'(cnt_q);
    assign busy      = (state_q == SYNC) || (state_q == CAPTURE);
    assign done      = (state_q == DONE);
    assign frame_err = err_q;

endmodule

// File: tb/tb_spec_bram_writer.sv
// Self-checking bench for spec_bram_writer: vector table, directed frame scenarios
// and a randomized stream checked against a behavioural capture model.
module tb_spec_bram_writer;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int FL = 1024;

    logic          clk = 1'b0;
    logic          rst, arm, s_tvalid, s_tlast;
    logic [DW-1:0] s_tdata;
    logic          s_tready, bram_en, bram_we, busy, done, frame_err;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [31:0]   status;

    int n_assert = 0;
    int n_fail   = 0;

    spec_bram_writer #(.DATA_W(DW), .ADDR_W(AW), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst(rst), .arm(arm),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .status(status), .busy(busy), .done(done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: an armed session, whether a frame boundary has been seen,
    // how many bins of the current frame are stored, and whether the frame is full.
    bit        m_active, m_locked, m_full, m_err;
    int        m_count;
    bit        e_we;
    int        e_addr;
    logic [31:0] e_din;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit a, input bit v, input bit l, input logic [31:0] d);
        e_we = 1'b0;
        if (r) begin
            m_active = 0; m_locked = 0; m_full = 0; m_err = 0; m_count = 0;
        end else if (!m_active) begin
            if (a) begin
                m_active = 1; m_locked = 0; m_full = 0; m_count = 0; m_err = 0;
            end
        end else begin
            if (m_locked && !m_full && v) begin
                if (l == (m_count == FL - 1)) begin
                    e_we = 1'b1; e_addr = m_count; e_din = d;
                    m_count++;
                    if (l) m_full = 1;
                end else begin
                    m_err = 1; m_count = 0; m_locked = l;
                end
            end else if (!m_locked && v && l) begin
                m_locked = 1;
            end
            if (!a) begin
                m_active = 0; m_err = 0;
            end
        end
    endtask

    task automatic step(input bit r, input bit a, input bit v, input bit l, input logic [31:0] d);
        rst = r; arm = a; s_tvalid = v; s_tlast = l; s_tdata = d;
        model(r, a, v, l, d);
        @(posedge clk);
        #1;
        chk("we", 64'(bram_we), 64'(e_we));
        chk("en", 64'(bram_en), 64'(e_we));
        if (e_we) begin
            chk("addr", 64'(bram_addr), 64'(e_addr));
            chk("din", 64'(bram_din), 64'(e_din));
        end
        chk("status", 64'(status), 64'(m_count));
        chk("busy", 64'(busy), 64'(m_active && !m_full));
        chk("done", 64'(done), 64'(m_active && m_full));
        chk("frame_err", 64'(frame_err), 64'(m_err));
        chk("tready", 64'(s_tready), 64'd1);
    endtask

    // n beats with data = base+i; tlast on index last_idx (-1: none); gap inserts an idle cycle before each beat
    task automatic stream(input bit a, input int n, input int last_idx, input int base, input bit gap);
        for (int i = 0; i < n; i++) begin
            if (gap) step(0, a, 0, 0, 32'hDEAD_BEEF);
            step(0, a, 1, (i == last_idx), 32'(base + i));
        end
    endtask

    typedef struct {
        bit r, a, v, l;
        logic [31:0] d;
        bit we;
        int addr;
        logic [31:0] din;
        int st;
        bit busy, done, err;
    } vec_t;

    vec_t tbl[14];

    initial begin
        rst = 1; arm = 0; s_tvalid = 0; s_tlast = 0; s_tdata = '0;
        m_active = 0; m_locked = 0; m_full = 0; m_err = 0; m_count = 0;
        e_addr = 0; e_din = '0; e_we = 0;

        //         r a v l  data  we addr din  st busy done err
        tbl[0]  = '{1,0,0,0, 0,    0, 0,   0,   0, 0,0,0};
        tbl[1]  = '{0,0,1,1, 9,    0, 0,   0,   0, 0,0,0};
        tbl[2]  = '{0,1,0,0, 0,    0, 0,   0,   0, 1,0,0};
        tbl[3]  = '{0,1,1,0, 5,    0, 0,   0,   0, 1,0,0};
        tbl[4]  = '{0,1,1,1, 6,    0, 0,   0,   0, 1,0,0};
        tbl[5]  = '{0,1,1,0, 100,  1, 0,   100, 1, 1,0,0};
        tbl[6]  = '{0,1,0,0, 0,    0, 0,   0,   1, 1,0,0};
        tbl[7]  = '{0,1,1,0, 101,  1, 1,   101, 2, 1,0,0};
        tbl[8]  = '{0,1,1,1, 102,  0, 0,   0,   0, 1,0,1};
        tbl[9]  = '{0,1,1,0, 200,  1, 0,   200, 1, 1,0,1};
        tbl[10] = '{0,0,1,0, 201,  1, 1,   201, 2, 0,0,0};
        tbl[11] = '{0,0,0,0, 0,    0, 0,   0,   2, 0,0,0};
        tbl[12] = '{0,1,0,0, 0,    0, 0,   0,   0, 1,0,0};
        tbl[13] = '{0,0,0,0, 0,    0, 0,   0,   0, 0,0,0};

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].r, tbl[i].a, tbl[i].v, tbl[i].l, tbl[i].d);
            chk("tbl_we", 64'(bram_we), 64'(tbl[i].we));
            chk("tbl_status", 64'(status), 64'(tbl[i].st));
            chk("tbl_busy", 64'(busy), 64'(tbl[i].busy));
            chk("tbl_done", 64'(done), 64'(tbl[i].done));
            chk("tbl_err", 64'(frame_err), 64'(tbl[i].err));
            if (tbl[i].we || tbl[i].r) begin
                chk("tbl_addr", 64'(bram_addr), 64'(tbl[i].addr));
                chk("tbl_din", 64'(bram_din), 64'(tbl[i].din));
            end
        end

        // Partial frame then a full aligned frame, continuous beats
        step(0, 1, 0, 0, 0);
        stream(1, 300, 299, 5000, 0);
        stream(1, FL, FL - 1, 0, 0);
        chk("full_done", 64'(done), 64'd1);
        chk("full_last_we", 64'(bram_we), 64'd1);
        chk("full_last_addr", 64'(bram_addr), 64'(FL - 1));
        chk("full_last_din", 64'(bram_din), 64'(FL - 1));
        chk("full_status", 64'(status), 64'(FL));
        chk("full_busy", 64'(busy), 64'd0);
        stream(1, 5, -1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("disarm_status", 64'(status), 64'(FL));
        chk("disarm_done", 64'(done), 64'd0);

        // Same stimulus with valid toggling
        step(0, 1, 0, 0, 0);
        stream(1, 50, 49, 7000, 1);
        stream(1, FL, FL - 1, 0, 1);
        chk("gap_done", 64'(done), 64'd1);
        chk("gap_last_addr", 64'(bram_addr), 64'(FL - 1));
        chk("gap_last_din", 64'(bram_din), 64'(FL - 1));
        step(0, 0, 0, 0, 0);

        // Arm mid-frame: nothing written until after the next tlast
        stream(0, 400, -1, 0, 0);
        stream(1, 624, 623, 400, 0);
        step(0, 1, 1, 0, 32'd777);
        chk("mid_first_addr", 64'(bram_addr), 64'd0);
        chk("mid_first_din", 64'(bram_din), 64'd777);
        chk("mid_status", 64'(status), 64'd1);

        // Misaligned tlast at bin 500 restarts the capture directly
        stream(1, 500, 499, 1, 0);
        chk("err_flag", 64'(frame_err), 64'd1);
        chk("err_status", 64'(status), 64'd0);
        chk("err_we", 64'(bram_we), 64'd0);
        stream(1, FL, FL - 1, 0, 0);
        chk("err_then_done", 64'(done), 64'd1);
        chk("err_sticky", 64'(frame_err), 64'd1);
        step(0, 0, 0, 0, 0);

        // Drop arm at status 600
        step(0, 1, 0, 0, 0);
        stream(1, 1, 0, 0, 0);
        stream(1, 600, -1, 0, 0);
        chk("abort_pre", 64'(status), 64'd600);
        step(0, 0, 0, 0, 0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_status", 64'(status), 64'd600);
        stream(0, 3, -1, 0, 0);
        chk("abort_hold", 64'(status), 64'd600);
        step(0, 1, 0, 0, 0);
        chk("rearm_status", 64'(status), 64'd0);

        // Reset at status 300 with a beat in flight
        stream(1, 1, 0, 0, 0);
        stream(1, 300, -1, 0, 0);
        chk("rst_pre", 64'(status), 64'd300);
        step(1, 1, 1, 0, 32'h1234);
        chk("rst_addr", 64'(bram_addr), 64'd0);
        chk("rst_din", 64'(bram_din), 64'd0);
        chk("rst_status", 64'(status), 64'd0);
        step(0, 1, 0, 0, 0);
        stream(1, 1, 0, 0, 0);
        stream(1, FL, FL - 1, 0, 0);
        chk("post_rst_done", 64'(done), 64'd1);
        step(0, 0, 0, 0, 0);

        // Randomized stream: mostly aligned frames, occasional odd-length frames and disarms
        begin
            int  bin  = 0;
            int  flen = FL;
            bit  a, v, l;
            for (int c = 0; c < 8000; c++) begin
                a = ($urandom_range(0, 2999) != 0);
                v = ($urandom_range(0, 3) != 0);
                l = 0;
                if (v) begin
                    l = (bin == flen - 1);
                    bin++;
                    if (l) begin
                        bin  = 0;
                        flen = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 1100)) : FL;
                    end
                end
                step(0, a, v, l, $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
